// File: rtl/pq_drain_if.sv
// rtl/pq_drain_if.sv - PQ dequeue port and output stream of the burst drain engine
interface pq_drain_if #(
  parameter int KEY_W = 16,
  parameter int VAL_W = 16
);
  logic                     pq_deq;
  logic [KEY_W+VAL_W-1:0]   pq_kvo;
  logic                     pq_empty;
  logic                     pq_busy;
  logic                     out_valid;
  logic                     out_ready;
  logic [KEY_W+VAL_W-1:0]   out_kv;

  modport master (
    output pq_deq, out_valid, out_kv,
    input  pq_kvo, pq_empty, pq_busy, out_ready
  );

  modport slave (
    input  pq_deq, out_valid, out_kv,
    output pq_kvo, pq_empty, pq_busy, out_ready
  );
endinterface

// File: rtl/pq_drain.sv
// rtl/pq_drain.sv - burst drain engine: dequeues heap PQ pairs into a 2-entry output buffer
// Optional key-order checker enabled by defining PQ_DRAIN_ORDER_CHK_EN.
module pq_drain #(
  parameter int KEY_W = 16,
  parameter int VAL_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  pq_drain_if.master       io,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] drained,
  output logic             order_err
);
  localparam int KV_W = KEY_W + VAL_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  drained_q, drained_d, drained_inc;
  logic [1:0]        cnt_q, cnt_d;
  logic              wptr_q, wptr_d, rptr_q, rptr_d;
  logic [KV_W-1:0]   buf_q [2];
  logic [KV_W-1:0]   buf_d [2];
  logic              start_acc, at_limit, deq, pop;

  // The deq decision uses only registered count, so out_ready never reaches pq_deq.
  always_comb begin
    start_acc   = (state_q == S_IDLE) && start;
    at_limit    = (len_q != '0) && (drained_q == len_q);
    deq         = (state_q == S_RUN) && !io.pq_empty && !io.pq_busy &&
                  (cnt_q != 2'd2) && !at_limit;
    pop         = (cnt_q != 2'd0) && io.out_ready;
    drained_inc = drained_q + {{(CNT_W-1){1'b0}}, deq};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (((len_q != '0) && (drained_inc == len_q)) ||
                   (io.pq_empty && !io.pq_busy)) state_d = S_FLUSH;
      S_FLUSH: if (cnt_q == 2'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    drained      = drained_q;
    io.pq_deq    = deq;
    io.out_valid = (cnt_q != 2'd0);
    io.out_kv    = buf_q[rptr_q];
  end

  always_comb begin
    len_d     = len_q;
    drained_d = drained_inc;
    cnt_d     = cnt_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    buf_d     = buf_q;
    if (start_acc) begin
      len_d     = burst_len;
      drained_d = '0;
    end
    if (deq) begin
      buf_d[wptr_q] = io.pq_kvo;
      wptr_d        = !wptr_q;
    end
    if (pop) rptr_d = !rptr_q;
    case ({deq, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q     <= '0;
      drained_q <= '0;
      cnt_q     <= 2'd0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
    end else begin
      len_q     <= len_d;
      drained_q <= drained_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      buf_q     <= buf_d;
    end
  end

`ifdef PQ_DRAIN_ORDER_CHK_EN
  logic [KEY_W-1:0] last_key_q, last_key_d, pop_key;
  logic             have_key_q, have_key_d;
  logic             order_err_q, order_err_d;

  // The first pop of a burst only seeds the reference key.
  always_comb begin
    pop_key     = buf_q[rptr_q][KV_W-1 -: KEY_W];
    last_key_d  = last_key_q;
    have_key_d  = have_key_q;
    order_err_d = order_err_q;
    if (start_acc) begin
      have_key_d  = 1'b0;
      order_err_d = 1'b0;
    end else if (pop) begin
      if (have_key_q && (pop_key < last_key_q)) order_err_d = 1'b1;
      last_key_d = pop_key;
      have_key_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_key_q  <= '0;
      have_key_q  <= 1'b0;
      order_err_q <= 1'b0;
    end else begin
      last_key_q  <= last_key_d;
      have_key_q  <= have_key_d;
      order_err_q <= order_err_d;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif
endmodule

// File: tb/tb_pq_drain.sv
// tb/tb_pq_drain.sv - directed bench for pq_drain with a FIFO PQ model and burst-level scoreboard
module tb_pq_drain;
  localparam int KEY_W = 16;
  localparam int VAL_W = 16;
  localparam int CNT_W = 8;
  localparam int KV_W  = KEY_W + VAL_W;
`ifdef PQ_DRAIN_ORDER_CHK_EN
  localparam logic ORD_EN = 1'b1;
`else
  localparam logic ORD_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] burst_len = '0;
  logic             busy, done, order_err;
  logic [CNT_W-1:0] drained;

  pq_drain_if #(.KEY_W(KEY_W), .VAL_W(VAL_W)) io ();

  pq_drain #(.KEY_W(KEY_W), .VAL_W(VAL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst_n), .start(start), .burst_len(burst_len), .io(io),
    .busy(busy), .done(done), .drained(drained), .order_err(order_err)
  );

  always #5 clk = ~clk;

  logic [KV_W-1:0] pq_q[$];
  logic [KV_W-1:0] exp_out[$];
  logic            exp_err = 1'b0;
  int              n_chk = 0;
  int              n_fail = 0;
  logic            deq_seen = 1'b0;
  int              out_idx = 0;
  int              deq_cnt = 0;
  logic            hold_v = 1'b0;
  logic [KV_W-1:0] hold_kv = '0;

  function automatic logic [KV_W-1:0] kv(input int k);
    logic [15:0] kk;
    kk = k[15:0];
    return {kk, kk ^ 16'hA5A5};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    io.pq_empty = (pq_q.size() == 0);
    io.pq_kvo   = (pq_q.size() != 0) ? pq_q[0] : '0;
  endtask

  task automatic push(input int k);
    pq_q.push_back(kv(k));
    refresh();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (deq_seen && pq_q.size() != 0) void'(pq_q.pop_front());
    refresh();
  endtask

  // Expected burst: the first n queued pairs, n = burst_len (0 = all) capped by availability.
  task automatic plan(input int len);
    int n;
    n = (len == 0 || len > pq_q.size()) ? pq_q.size() : len;
    exp_out.delete();
    exp_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_out.push_back(pq_q[i]);
      if (i > 0 && pq_q[i][KV_W-1 -: KEY_W] < pq_q[i-1][KV_W-1 -: KEY_W]) exp_err = ORD_EN;
    end
  endtask

  task automatic begin_burst(input int len);
    plan(len);
    burst_len = len[CNT_W-1:0];
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    logic got;
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      step();
      if (done) got = 1'b1;
    end
    check(name, 64'(got), 64'(1));
  endtask

  // Compare process: every cycle, against the burst plan.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        deq_seen = 1'b0;
        out_idx  = 0;
        deq_cnt  = 0;
        hold_v   = 1'b0;
      end else begin
        if (start && !busy) begin
          out_idx = 0;
          deq_cnt = 0;
        end
        deq_seen = io.pq_deq;
        if (io.pq_deq) begin
          check("deq_legal", 64'({io.pq_busy, io.pq_empty}), 64'(0));
          deq_cnt++;
        end
        if (hold_v && io.out_valid) check("kv_hold", 64'(io.out_kv), 64'(hold_kv));
        if (io.out_valid && io.out_ready) begin
          if (out_idx < exp_out.size()) check("out_kv", 64'(io.out_kv), 64'(exp_out[out_idx]));
          else check("extra_out", 64'(out_idx + 1), 64'(exp_out.size()));
          out_idx++;
        end
        hold_v  = io.out_valid && !io.out_ready;
        hold_kv = io.out_kv;
        if (done) begin
          check("burst_outputs", 64'(out_idx), 64'(exp_out.size()));
          check("burst_deqs", 64'(deq_cnt), 64'(exp_out.size()));
          check("burst_drained", 64'(drained), 64'(exp_out.size()));
          check("burst_order_err", 64'(order_err), 64'(exp_err));
        end
      end
    end
  end

  initial begin
    io.pq_busy = 1'b0;
    io.out_ready = 1'b1;
    refresh();
    repeat (2) @(posedge clk);
    #1;
    check("rst_deq", 64'(io.pq_deq), 64'(0));
    check("rst_valid", 64'(io.out_valid), 64'(0));
    check("rst_kv", 64'(io.out_kv), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_drained", 64'(drained), 64'(0));
    rst_n = 1'b1;
    step();

    // 3,5,9 drain-until-empty with exact cycle timing
    push(3); push(5); push(9);
    begin_burst(0);
    check("t1_c1_busy", 64'(busy), 64'(1));
    check("t1_c1_deq", 64'(io.pq_deq), 64'(1));
    check("t1_c1_valid", 64'(io.out_valid), 64'(0));
    step();
    check("t1_c2_kv", 64'({io.out_valid, io.out_kv}), 64'({1'b1, 32'h0003A5A6}));
    step();
    check("t1_c3_kv", 64'({io.out_valid, io.out_kv}), 64'({1'b1, 32'h0005A5A0}));
    step();
    check("t1_c4_kv", 64'({io.out_valid, io.out_kv}), 64'({1'b1, 32'h0009A5AC}));
    step();
    check("t1_c5", 64'({io.out_valid, done, busy}), 64'(3'b001));
    step();
    check("t1_c6_done", 64'(done), 64'(1));
    check("t1_c6_drained", 64'(drained), 64'(3));
    step();
    check("t1_c7_idle", 64'({done, busy}), 64'(0));

    // bounded burst leaves the rest in the PQ
    for (int k = 1; k <= 10; k++) push(k);
    begin_burst(4);
    wait_done("t2_done", 40);
    check("t2_drained", 64'(drained), 64'(4));
    check("t2_left", 64'(pq_q.size()), 64'(6));
    check("t2_head", 64'(io.pq_kvo), 64'(kv(5)));
    pq_q.delete(); refresh();
    step();

    // backpressure: two deqs then stall, head held
    for (int k = 20; k < 25; k++) push(k);
    io.out_ready = 1'b0;
    begin_burst(0);
    repeat (4) step();
    check("t3_left", 64'(pq_q.size()), 64'(3));
    check("t3_head", 64'({io.out_valid, io.out_kv}), 64'({1'b1, kv(20)}));
    io.out_ready = 1'b1;
    wait_done("t3_done", 40);
    step();

    // pq_busy toggling
    for (int k = 30; k < 34; k++) push(k);
    begin_burst(0);
    begin
      logic got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        io.pq_busy = !io.pq_busy;
        step();
        if (done) got = 1'b1;
      end
      io.pq_busy = 1'b0;
      check("t4_done", 64'(got), 64'(1));
    end
    check("t4_drained", 64'(drained), 64'(4));
    step();

    // reset with two buffered pairs
    for (int k = 40; k < 46; k++) push(k);
    io.out_ready = 1'b0;
    begin_burst(0);
    step(); step();
    check("t5_left", 64'(pq_q.size()), 64'(4));
    rst_n = 1'b0;
    #1;
    check("t5_rst", 64'({io.pq_deq, io.out_valid, busy, done, order_err}), 64'(0));
    check("t5_rst_kv", 64'(io.out_kv), 64'(0));
    check("t5_rst_drained", 64'(drained), 64'(0));
    step();
    rst_n = 1'b1;
    io.out_ready = 1'b1;
    begin_burst(0);
    wait_done("t5_done", 40);
    check("t5_drained", 64'(drained), 64'(4));
    step();

    // empty PQ timing; start during DONE is ignored
    begin_burst(0);
    check("t6_c1", 64'({busy, done}), 64'(2'b10));
    step();
    check("t6_c2", 64'({busy, done}), 64'(2'b10));
    step();
    check("t6_c3", 64'({busy, done}), 64'(2'b11));
    start = 1'b1;
    step();
    start = 1'b0;
    check("t6_c4", 64'({busy, done}), 64'(0));
    step();
    check("t6_c5", 64'(busy), 64'(0));

    // burst_len larger than available
    push(50); push(51); push(52);
    begin_burst(8);
    wait_done("t7_done", 40);
    check("t7_drained", 64'(drained), 64'(3));
    check("t7_empty", 64'(io.pq_empty), 64'(1));
    step();

    // descending keys: order_err behaviour depends on build
    push(4); push(2);
    begin_burst(0);
    wait_done("t8_done", 40);
    check("t8_err", 64'(order_err), 64'(ORD_EN));
    step(); step();
    check("t8_err_held", 64'(order_err), 64'(ORD_EN));
    push(7);
    begin_burst(0);
    check("t8_err_clr", 64'(order_err), 64'(0));
    wait_done("t8b_done", 40);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pq_drain.md
# pq_drain

Burst drain engine sitting directly downstream of the heap priority queue. On a start command it dequeues up to a programmed number of key-value pairs, or until the queue reports empty, and presents them in priority order on a valid/ready output stream. A 2-entry output buffer gives full one-item-per-cycle throughput with no combinational path from `out_ready` to `pq_deq`. A single-cycle `done` pulse closes each burst.

## Interface
- `KEY_W`, 16, key width; key is the MSB field of a pair.
- `VAL_W`, 16, value width; value is the LSB field.
- `CNT_W`, 8, width of burst length and drain counter.

Ports:
- `clk`  input  1  single clock; all state changes on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  begin burst; sampled only in IDLE.
- `burst_len`  input  CNT_W  items to drain; 0 = drain until empty; latched on accepted `start`.
- `pq_deq`  output  1  dequeue request to the PQ.
- `pq_kvo`  input  KEY_W+VAL_W  current PQ head (minimum) pair.
- `pq_empty`  input  1  PQ empty.
- `pq_busy`  input  1  PQ busy; no `pq_deq` while high.
- `out_valid`  output  1  `out_kv` valid.
- `out_ready`  input  1  downstream accepts.
- `out_kv`  output  KEY_W+VAL_W  head of output buffer.
- `busy`  output  1  state != IDLE.
- `done`  output  1  one-cycle pulse at burst end.
- `drained`  output  CNT_W  items dequeued in current or last burst.
- `order_err`  output  1  sticky key-order violation; see Configuration.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on `start`. This latches `burst_len`, clears `drained` and `order_err`.
  - RUN -> FLUSH when `burst_len`!=0 and `drained`==`burst_len` (including via the current deq), or when `pq_empty` && !`pq_busy`.
  - FLUSH -> DONE when buffer count == 0.
  - DONE -> IDLE unconditionally; `done`=1 only in DONE.
- `pq_deq` = RUN && !`pq_empty` && !`pq_busy` && count<2 && !(`burst_len`!=0 && `drained`==`burst_len`).
- On `pq_deq`, `pq_kvo` is written into the buffer tail at the same edge, and `drained` increments.
- Buffer: 2 entries, read/write pointers plus 2-bit count.
  - `out_valid` = count!=0.
  - Pop on `out_valid && out_ready`.
  - Simultaneous push and pop keeps count unchanged.
- `out_kv` is stable while `out_valid` && !`out_ready`.
- `start` outside IDLE is ignored. `start` in the DONE cycle is ignored.
- `burst_len` > available items: burst ends on empty with `drained` < `burst_len`; no error.
- Reset values: state IDLE, count 0, pointers 0, `pq_deq` 0, `out_valid` 0, `out_kv` 0, `busy` 0, `done` 0, `drained` 0, `order_err` 0.
- Reset mid-burst discards buffered pairs. Those pairs are already removed from the PQ and are lost by design.

## Timing
- `start` high at edge 0 -> RUN in cycle 1 -> first `pq_deq` in cycle 1 -> first `out_valid` in cycle 2.
- Start-to-first-output latency: 2 cycles.
- Sustained throughput: 1 item/cycle with `out_ready` held high and `pq_busy` low.
- Empty PQ with `burst_len`=0:
  - cycle 1: RUN
  - cycle 2: FLUSH
  - cycle 3: DONE, `done`=1
  - cycle 4: IDLE
- `drained` is valid from DONE until the next accepted `start`.
- `pq_busy` high stalls `pq_deq`; it does not end RUN.

## Configuration
- `PQ_DRAIN_ORDER_CHK_EN` defined:
  - Registers the key of each popped pair within a burst.
  - `order_err` is set and held if a popped key is less than the previous popped key (unsigned).
  - `order_err` is cleared on accepted `start`.
- Undefined: no key register; `order_err` tied to 0.

## Test plan
- PQ holds keys 3,5,9; `start` with `burst_len`=0 and `out_ready`=1 -> outputs 3,5,9 in cycles 2-4; `drained`=3; `done` in cycle 6.
- PQ holds 10 items; `burst_len`=4 -> exactly 4 `pq_deq` pulses, 4 outputs, 6 items remain, `drained`=4.
- `out_ready`=0 for 5 cycles after `start` -> exactly 2 `pq_deq` then stall; `out_kv` holds the first key; releasing `out_ready` drains in order with no loss or duplication.
- `pq_busy` toggled every other cycle during a 4-item burst -> `pq_deq` never coincides with `pq_busy`; all 4 items are delivered.
- Reset asserted in RUN with count 2 -> all outputs at reset values immediately; next `start` proceeds normally.
- With `PQ_DRAIN_ORDER_CHK_EN`: PQ model returns keys 4 then 2 -> `order_err`=1 after the second pop; stays 1 until the next `start`.
